// File: rtl/i4001_rom_pkg.sv
// Shared definitions for the 4001 ROM model: instruction phases and I/O opcode constants.
package i4001_rom_pkg;

   typedef enum logic [3:0] {
      PH_IDLE,
      PH_A1,
      PH_A2,
      PH_A3,
      PH_M1,
      PH_M2,
      PH_X1,
      PH_X2,
      PH_X3
   } phase_t;

   localparam logic [3:0] OP_IO  = 4'hE;
   localparam logic [3:0] FN_WRR = 4'h2;
   localparam logic [3:0] FN_RDR = 4'hA;

   // A low sync always restarts at A1, whatever phase we believed we were in.
   function automatic phase_t next_phase(input phase_t ph, input logic sync);
      phase_t nxt;
      nxt = PH_IDLE;
      if (!sync) begin
         nxt = PH_A1;
      end else begin
         case (ph)
            PH_IDLE: nxt = PH_IDLE;
            PH_A1:   nxt = PH_A2;
            PH_A2:   nxt = PH_A3;
            PH_A3:   nxt = PH_M1;
            PH_M1:   nxt = PH_M2;
            PH_M2:   nxt = PH_X1;
            PH_X1:   nxt = PH_X2;
            PH_X2:   nxt = PH_X3;
            PH_X3:   nxt = PH_IDLE;
            default: nxt = PH_IDLE;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/i4001_mem.sv
// 256 x 8 program store: synchronous write port for loading, asynchronous read for fetch.
module i4001_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [256];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/i4001_rom.sv
// 4001 ROM + I/O port: tracks the CPU instruction phases, drives fetched nibbles and
// services SRC/WRR/RDR on its own 4-bit port.
//
// state   | meaning
// --------+------------------------------------------------------------
// PH_IDLE | waiting for sync low
// PH_A1   | bus carries address bits [3:0]
// PH_A2   | bus carries address bits [7:4]
// PH_A3   | bus carries bank number; cm_rom marks a ROM bank select
// PH_M1   | opcode high nibble (driven by us when selected)
// PH_M2   | opcode low nibble (driven by us when selected)
// PH_X1   | execute, nothing for this chip
// PH_X2   | SRC chip nibble / WRR data / RDR port read
// PH_X3   | execute, CPU pulls sync low here
import i4001_rom_pkg::*;

module i4001_rom #(
   parameter logic [3:0] CHIP_ID = 4'h0
) (
   input  logic       cp2,
   input  logic       reset,
   input  logic       sync,
   input  logic       cm_rom,
   input  logic [3:0] data_in,
   output logic [3:0] data_out,
   output logic       data_oe,
   input  logic [3:0] io_in,
   output logic [3:0] io_out,
   input  logic       prog_we,
   input  logic [7:0] prog_addr,
   input  logic [7:0] prog_data
);

   phase_t     phase;
   logic [7:0] addr;
   logic [3:0] bank;
   logic       sel;
   logic [3:0] opr_snoop;
   logic [3:0] opa_snoop;
   logic       io_cyc;
   logic       src_sel;
   logic [3:0] io_q;
   logic [7:0] rom_word;

   i4001_mem u_mem (
      .clk   (cp2),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (addr),
      .rdata (rom_word)
   );

   always_ff @(posedge cp2) begin
      if (reset) begin
         phase     <= PH_IDLE;
         addr      <= 8'h00;
         bank      <= 4'h0;
         sel       <= 1'b0;
         opr_snoop <= 4'h0;
         opa_snoop <= 4'h0;
         io_cyc    <= 1'b0;
         src_sel   <= 1'b0;
         io_q      <= 4'h0;
      end else begin
         phase <= next_phase(phase, sync);
         // An early sync low abandons the current instruction without touching any latch.
         if (sync) begin
            case (phase)
               PH_A1: addr[3:0] <= data_in;
               PH_A2: addr[7:4] <= data_in;
               PH_A3: begin
                  bank <= data_in;
                  sel  <= cm_rom && (data_in == CHIP_ID);
               end
               PH_M1: opr_snoop <= data_in;
               PH_M2: begin
                  opa_snoop <= data_in;
                  io_cyc    <= cm_rom && (opr_snoop == OP_IO) &&
                               ((data_in == FN_WRR) || (data_in == FN_RDR));
               end
               PH_X2: begin
                  // A chip select at X2 wins over any pending port write.
                  if (cm_rom) begin
                     src_sel <= (data_in == CHIP_ID);
                  end else if (io_cyc && (opa_snoop == FN_WRR) && src_sel) begin
                     io_q <= data_in;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      data_oe  = 1'b0;
      data_out = 4'h0;
      case (phase)
         PH_M1: begin
            if (sel && (bank == CHIP_ID)) begin
               data_oe  = 1'b1;
               data_out = rom_word[7:4];
            end
         end
         PH_M2: begin
            if (sel && (bank == CHIP_ID)) begin
               data_oe  = 1'b1;
               data_out = rom_word[3:0];
            end
         end
         PH_X2: begin
            if (io_cyc && (opa_snoop == FN_RDR) && src_sel) begin
               data_oe  = 1'b1;
               data_out = io_in;
            end
         end
         default: ;
      endcase
   end

   assign io_out = io_q;

endmodule
